// File: rtl/ll_pkg.sv
// Package: ll_pkg
// Shared types and defaults for the linked-list write path.
//   t_wr_arb_st      : state encoding of the ll_wr_arb sequencer
//   WR_DATA_WD_DEF   : default payload width (matches ll_wr_ctrl data_to_wr)
//   ARB_TIMEOUT_DEF  : default ISSUE cycles allowed before a write is aborted
package ll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } t_wr_arb_st;

    localparam int WR_DATA_WD_DEF  = 32;
    localparam int ARB_TIMEOUT_DEF = 64;

endpackage

// File: rtl/ll_rr_pick.sv
// Module: ll_rr_pick
// Combinational round-robin picker. Searches the request vector starting at
// rr_ptr and moving upward, wrapping past NUM_REQ-1 back to 0.
// Ports:
//   req      in  NUM_REQ  request vector
//   rr_ptr   in  IW       index with highest priority this round
//   win_idx  out IW       index of the winner (valid when any_req=1)
//   win_oh   out NUM_REQ  one-hot form of win_idx
//   any_req  out 1        at least one request bit set
module ll_rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      rr_ptr,
    output logic [IW-1:0]      win_idx,
    output logic [NUM_REQ-1:0] win_oh,
    output logic               any_req
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [IW:0]          win_ofs;
    logic [IW:0]          win_sum;
    logic                 found;

    // Rotate so that bit 0 of req_rot is the client at rr_ptr; duplicating
    // the vector makes the wrap-around fall out of a plain right shift.
    assign req_dbl = {req, req};
    assign req_rot = NUM_REQ'(req_dbl >> rr_ptr);

    always_comb begin
        win_ofs = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_rot[k]) begin
                found   = 1'b1;
                win_ofs = (IW+1)'(k);
            end
        end
        // Undo the rotation: (rr_ptr + offset) mod NUM_REQ, NUM_REQ need not be 2^n.
        win_sum = {1'b0, rr_ptr} + win_ofs;
        if (win_sum >= (IW+1)'(NUM_REQ)) begin
            win_sum = win_sum - (IW+1)'(NUM_REQ);
        end
        win_idx = win_sum[IW-1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_oh
            assign win_oh[gi] = (win_idx == IW'(gi));
        end
    endgenerate

    assign any_req = |req;

endmodule

// File: rtl/ll_wr_arb.sv
// Module: ll_wr_arb
// Round-robin arbiter/sequencer sharing one ll_wr_ctrl among NUM_REQ clients.
// Latches the winner's payload and insert flag, drives the controller request,
// tracks the write until the controller is ready again and then reports done
// (or a timeout abort) back to the winning client.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   req_vld/req_data/req_insert   per-client request, payload, insert flag
//   req_ack/req_done/req_err      per-client 1-cycle one-hot pulses
//   data_to_wr, data_to_wr_req, insert_data   to ll_wr_ctrl
//   wr_ctrl_fsm_ready      from ll_wr_ctrl, 1 = idle
//   grant_id               current/last winner index
//   arb_busy               1 while a transaction is in flight
//   err_timeout            sticky abort flag, cleared by reset only
module ll_wr_arb
    import ll_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int WR_DATA_WD  = WR_DATA_WD_DEF,
    parameter  int TIMEOUT_CYC = ARB_TIMEOUT_DEF,
    localparam int IW          = $clog2(NUM_REQ),
    localparam int CW          = $clog2(TIMEOUT_CYC)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [NUM_REQ*WR_DATA_WD-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_insert,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            req_done,
    output logic [NUM_REQ-1:0]            req_err,
    output logic [WR_DATA_WD-1:0]         data_to_wr,
    output logic                          data_to_wr_req,
    output logic                          insert_data,
    input  logic                          wr_ctrl_fsm_ready,
    output logic [IW-1:0]                 grant_id,
    output logic                          arb_busy,
    output logic                          err_timeout
);

    t_wr_arb_st           state_reg;
    logic [IW-1:0]        rr_ptr_reg;
    logic [CW-1:0]        tmo_cnt_reg;
    logic                 abort_reg;

    logic [WR_DATA_WD-1:0] data_arr [NUM_REQ];
    logic [IW-1:0]         win_idx;
    logic [NUM_REQ-1:0]    win_oh;
    logic                  any_req;
    logic [NUM_REQ-1:0]    grant_oh;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cli
            assign data_arr[gi] = req_data[gi*WR_DATA_WD +: WR_DATA_WD];
            assign grant_oh[gi] = (grant_id == IW'(gi));
        end
    endgenerate

    ll_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req     (req_vld),
        .rr_ptr  (rr_ptr_reg),
        .win_idx (win_idx),
        .win_oh  (win_oh),
        .any_req (any_req)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            rr_ptr_reg     <= '0;
            tmo_cnt_reg    <= '0;
            abort_reg      <= 1'b0;
            req_ack        <= '0;
            req_done       <= '0;
            req_err        <= '0;
            data_to_wr     <= '0;
            data_to_wr_req <= 1'b0;
            insert_data    <= 1'b0;
            grant_id       <= '0;
            arb_busy       <= 1'b0;
            err_timeout    <= 1'b0;
        end else begin
            req_ack  <= '0;
            req_done <= '0;
            req_err  <= '0;
            case (state_reg)
                ST_IDLE: begin
                    // Only start when the controller is idle, so the request
                    // edge is always seen by ll_wr_ctrl in its ready state.
                    if (any_req && wr_ctrl_fsm_ready) begin
                        data_to_wr     <= data_arr[win_idx];
                        insert_data    <= req_insert[win_idx];
                        grant_id       <= win_idx;
                        req_ack        <= win_oh;
                        data_to_wr_req <= 1'b1;
                        tmo_cnt_reg    <= '0;
                        abort_reg      <= 1'b0;
                        arb_busy       <= 1'b1;
                        state_reg      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Controller leaving ready is the acceptance indication.
                    if (!wr_ctrl_fsm_ready) begin
                        data_to_wr_req <= 1'b0;
                        state_reg      <= ST_BUSY;
                    end else if (tmo_cnt_reg == CW'(TIMEOUT_CYC-1)) begin
                        data_to_wr_req <= 1'b0;
                        abort_reg      <= 1'b1;
                        state_reg      <= ST_DONE;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (wr_ctrl_fsm_ready) begin
                        state_reg <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    req_done <= grant_oh;
                    if (abort_reg) begin
                        req_err     <= grant_oh;
                        err_timeout <= 1'b1;
                    end
                    rr_ptr_reg  <= (grant_id == IW'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;
                    data_to_wr  <= '0;
                    insert_data <= 1'b0;
                    tmo_cnt_reg <= '0;
                    arb_busy    <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
                default: begin
                    arb_busy  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ll_wr_arb.sv
module tb_ll_wr_arb;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 8;

    logic           clk;
    logic           reset_n;
    logic [N-1:0]   req_vld;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_insert;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   req_done;
    logic [N-1:0]   req_err;
    logic [W-1:0]   data_to_wr;
    logic           data_to_wr_req;
    logic           insert_data;
    logic           ready;
    logic [1:0]     grant_id;
    logic           arb_busy;
    logic           err_timeout;

    int total;
    int bad;
    logic [W-1:0] cdat [N];

    ll_wr_arb #(
        .NUM_REQ     (N),
        .WR_DATA_WD  (W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .req_vld           (req_vld),
        .req_data          (req_data),
        .req_insert        (req_insert),
        .req_ack           (req_ack),
        .req_done          (req_done),
        .req_err           (req_err),
        .data_to_wr        (data_to_wr),
        .data_to_wr_req    (data_to_wr_req),
        .insert_data       (insert_data),
        .wr_ctrl_fsm_ready (ready),
        .grant_id          (grant_id),
        .arb_busy          (arb_busy),
        .err_timeout       (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic         rdy;
        logic [N-1:0] ack;
        logic         wreq;
        logic [N-1:0] done;
        logic         busy;
        logic [1:0]   gid;
        logic         chk_data;
        logic [W-1:0] data;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req_vld = '0;
        ready   = 1'b1;
        step();
        step();
        chk("rst_ack",   64'(req_ack), 64'd0);
        chk("rst_done",  64'(req_done), 64'd0);
        chk("rst_err",   64'(req_err), 64'd0);
        chk("rst_data",  64'(data_to_wr), 64'd0);
        chk("rst_wreq",  64'(data_to_wr_req), 64'd0);
        chk("rst_ins",   64'(insert_data), 64'd0);
        chk("rst_gid",   64'(grant_id), 64'd0);
        chk("rst_busy",  64'(arb_busy), 64'd0);
        chk("rst_tmo",   64'(err_timeout), 64'd0);
        reset_n = 1'b1;
    endtask

    // Waits for a grant, checks it against exp_id, runs a short controller
    // handshake (ready low two cycles) and checks the matching done pulse.
    task automatic run_txn(input int exp_id, input bit drop);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            step();
            if (req_ack != '0) got = 1'b1;
        end
        chk("ack_seen", 64'(got), 64'd1);
        if (!got) return;
        chk("ack_onehot", 64'(req_ack), 64'd1 << exp_id);
        chk("grant_id",   64'(grant_id), 64'(exp_id));
        chk("issue_data", 64'(data_to_wr), 64'(cdat[exp_id]));
        chk("issue_ins",  64'(insert_data), 64'(req_insert[exp_id]));
        chk("issue_wreq", 64'(data_to_wr_req), 64'd1);
        if (drop) req_vld[exp_id] = 1'b0;
        ready = 1'b0;
        step();
        chk("accept_wreq", 64'(data_to_wr_req), 64'd0);
        step();
        ready = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 30 && !got; n++) begin
            step();
            if (req_done != '0) got = 1'b1;
        end
        chk("done_seen", 64'(got), 64'd1);
        chk("done_onehot", 64'(req_done), 64'd1 << exp_id);
        chk("done_err",    64'(req_err), 64'd0);
        $display("txn client=%0d data=0x%08h ack/done observed", exp_id, cdat[exp_id]);
    endtask

    initial begin
        int  hi;
        bit  got;
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        req_vld = '0;
        ready   = 1'b1;
        cdat[0] = 32'h1000_0000;
        cdat[1] = 32'h2000_0011;
        cdat[2] = 32'hA5A5_0001;
        cdat[3] = 32'h3C3C_0033;
        req_insert = 4'b1010;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = cdat[i];

        //            req      rdy   ack      wreq  done     busy  gid   chkd  data
        tv[0] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 32'hA5A5_0001};
        tv[1] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1, 32'hA5A5_0001};
        tv[2] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 32'h0};
        tv[3] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 32'h0};
        tv[4] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 32'h0};
        tv[5] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 32'h0};
        tv[6] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 32'h0};
        tv[7] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 32'h0};
        tv[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, 32'h0};
        tv[9] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1, 32'h0};

        // 1: single request on client 2, cycle-by-cycle vectors
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req_vld = tv[i].req;
            ready   = tv[i].rdy;
            step();
            chk($sformatf("t1_ack[%0d]", i),  64'(req_ack), 64'(tv[i].ack));
            chk($sformatf("t1_wreq[%0d]", i), 64'(data_to_wr_req), 64'(tv[i].wreq));
            chk($sformatf("t1_done[%0d]", i), 64'(req_done), 64'(tv[i].done));
            chk($sformatf("t1_err[%0d]", i),  64'(req_err), 64'd0);
            chk($sformatf("t1_busy[%0d]", i), 64'(arb_busy), 64'(tv[i].busy));
            chk($sformatf("t1_gid[%0d]", i),  64'(grant_id), 64'(tv[i].gid));
            if (tv[i].chk_data) begin
                chk($sformatf("t1_data[%0d]", i), 64'(data_to_wr), 64'(tv[i].data));
                chk($sformatf("t1_ins[%0d]", i),  64'(insert_data), 64'd0);
            end
        end
        $display("txn client=2 table sequence applied");

        // 2: all clients request continuously -> 0,1,2,3,0
        do_reset();
        req_vld = 4'b1111;
        run_txn(0, 1'b0);
        run_txn(1, 1'b0);
        run_txn(2, 1'b0);
        run_txn(3, 1'b0);
        run_txn(0, 1'b0);
        req_vld = '0;

        // 3: pointer at 3 (after granting 2), clients 0 and 3 -> 3 then 0
        do_reset();
        req_vld = 4'b0100;
        run_txn(2, 1'b1);
        req_vld = 4'b1001;
        run_txn(3, 1'b0);
        run_txn(0, 1'b0);
        req_vld = '0;

        // 4: ready stuck high -> 8 ISSUE cycles, then done+err, sticky flag
        do_reset();
        req_vld = 4'b0010;
        ready   = 1'b1;
        got     = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            if (req_ack != '0) got = 1'b1;
        end
        chk("t4_ack", 64'(req_ack), 64'h2);
        req_vld = '0;
        hi = data_to_wr_req ? 1 : 0;
        for (int n = 0; n < 40 && data_to_wr_req; n++) begin
            step();
            if (data_to_wr_req) hi++;
        end
        chk("t4_req_cycles", 64'(hi), 64'(TO));
        chk("t4_no_early_done", 64'(req_done), 64'd0);
        step();
        chk("t4_done", 64'(req_done), 64'h2);
        chk("t4_err",  64'(req_err), 64'h2);
        chk("t4_tmo",  64'(err_timeout), 64'd1);
        step();
        step();
        step();
        chk("t4_err_pulse_end", 64'(req_err), 64'd0);
        chk("t4_tmo_sticky", 64'(err_timeout), 64'd1);
        req_vld = 4'b0001;
        run_txn(0, 1'b1);
        chk("t4_tmo_after_ok", 64'(err_timeout), 64'd1);
        $display("txn client=1 timeout abort observed");

        // 5: controller not ready at request time -> no ack until ready
        do_reset();
        ready   = 1'b0;
        req_vld = 4'b0100;
        for (int n = 0; n < 5; n++) begin
            step();
            chk($sformatf("t5_no_ack[%0d]", n), 64'(req_ack), 64'd0);
        end
        ready = 1'b1;
        run_txn(2, 1'b1);

        // 6: async reset while BUSY, then pending request granted from client 0
        do_reset();
        req_vld = 4'b0001;
        run_txn(0, 1'b1);
        req_vld = 4'b0100;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            if (req_ack != '0) got = 1'b1;
        end
        chk("t6_ack2", 64'(req_ack), 64'h4);
        req_vld = '0;
        ready   = 1'b0;
        step();
        step();
        chk("t6_busy_before", 64'(arb_busy), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_busy", 64'(arb_busy), 64'd0);
        chk("t6_async_gid",  64'(grant_id), 64'd0);
        chk("t6_async_data", 64'(data_to_wr), 64'd0);
        chk("t6_async_outs", 64'({req_ack, req_done, req_err, data_to_wr_req, insert_data, err_timeout}), 64'd0);
        req_vld = 4'b0101;
        ready   = 1'b1;
        #1;
        reset_n = 1'b1;
        step();
        chk("t6_ack0",  64'(req_ack), 64'h1);
        chk("t6_gid0",  64'(grant_id), 64'd0);
        chk("t6_nodone", 64'(req_done), 64'd0);
        req_vld = '0;
        ready   = 1'b0;
        step();
        step();
        ready = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            step();
            if (req_done != '0) got = 1'b1;
        end
        chk("t6_done0", 64'(req_done), 64'h1);
        $display("txn client=0 granted after async reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
